mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified memory bus between the instruction-fetch requester (PC/IF side)
//  and the data requester (MEM stage load/store). It sequences each bus transaction and raises
//  per-requester stall requests into CTRL, so the pipeline freezes while a requester waits.
//  It sits between the core and the external memory. It replaces the direct rom_addr_o/rom_ce_o path.
// PARAMETERS
//  ADDR_W       32   address width, both requesters and the bus
//  DATA_W       32   data width; DATA_W/8 byte selects
//  TIMEOUT_CYC  255  max busy cycles without bus_ack before abort (>=2)
// PORTS
//  clk           in   1         system clock, rising edge
//  rst           in   1         asynchronous, active-low reset
//  if_req        in   1         fetch request; held with if_addr until if_ack
//  if_addr       in   ADDR_W    fetch address
//  if_rdata      out  DATA_W    fetched instruction, valid while if_ack=1
//  if_ack        out  1         one-cycle fetch completion pulse
//  if_stallreq   out  1         to CTRL: if_req & ~if_ack
//  mem_req       in   1         data request; held with the mem_* fields until mem_ack
//  mem_we        in   1         1=store, 0=load
//  mem_sel       in   DATA_W/8  byte enables
//  mem_addr      in   ADDR_W    data address
//  mem_wdata     in   DATA_W    store data
//  mem_rdata     out  DATA_W    load data, valid while mem_ack=1
//  mem_ack       out  1         one-cycle data completion pulse
//  mem_stallreq  out  1         to CTRL: mem_req & ~mem_ack
//  bus_req       out  1         bus transaction request, registered
//  bus_we        out  1         bus write enable, registered
//  bus_sel       out  DATA_W/8  bus byte enables, registered
//  bus_addr      out  ADDR_W    bus address, registered
//  bus_wdata     out  DATA_W    bus write data, registered
//  bus_rdata     in   DATA_W    bus read data, sampled when bus_ack=1
//  bus_ack       in   1         bus completion, one cycle, at earliest the cycle after bus_req rises
//  err           out  1         one-cycle pulse on timeout abort
// BEHAVIOUR
//  - Reset (rst=0, immediate): state=IDLE; all outputs 0; timeout counter 0. Reset mid-transaction
//    drops bus_req at once. No ack is issued for the in-flight transaction.
//  - FSM states: IDLE, IF_BUSY, MEM_BUSY.
//  - IDLE:
//    - mem_req=1 -> MEM_BUSY. Register bus_addr=mem_addr, bus_we=mem_we, bus_sel=mem_sel,
//      bus_wdata=mem_wdata, and set bus_req=1.
//    - else if_req=1 -> IF_BUSY. Register bus_addr=if_addr, bus_we=0, bus_sel=all 1s, bus_wdata=0,
//      and set bus_req=1.
//    - Strict priority: MEM beats IF when both are pending (older instruction first).
//    - bus_ack in IDLE is ignored.
//  - *_BUSY: bus_* outputs are held stable; the counter increments every cycle.
//    - On bus_ack=1: capture bus_rdata into the owner's rdata register (0 for a store); pulse the
//      owner's ack next cycle; bus_req=0; return to IDLE; clear the counter.
//    - After a transaction, IDLE lasts at least 1 cycle (turnaround). Back-to-back grants therefore
//      have one idle bus cycle between them.
//  - Timeout: counter reaching TIMEOUT_CYC with no bus_ack aborts the transaction.
//    - bus_req=0; err=1 for one cycle; owner's ack pulses with rdata=0; return to IDLE.
//    - The pipeline never hangs.
//  - Latency: request seen in IDLE at cycle 0; bus_req=1 in cycle 1; bus_ack at the earliest in
//    cycle 1; ack out in cycle 2. Minimum 2 cycles of stallreq, with stallreq low in the ack cycle.
//  - Requester drops req mid-transaction: the bus transaction still completes and is not aborted.
//    The ack is suppressed (stays 0). The FSM returns to IDLE normally.
//  - if_rdata/mem_rdata hold their last value between acks. They are only meaningful while ack=1.
//  - stallreq outputs are combinational from req and the registered ack. No other combinational
//    path runs from inputs to outputs.
//  - The counter saturates at TIMEOUT_CYC and never wraps.
// TESTING
//  - if_req=1, if_addr=0x100; bus_ack in cycle 1 with rdata=0x2402_0005 -> if_ack in cycle 2 with
//    if_rdata=0x2402_0005; if_stallreq=1 in cycles 0-1 only.
//  - if_req and mem_req both 1 in cycle 0, mem_addr=0x40 load -> bus_addr=0x40 first; mem_ack;
//    one idle cycle; then bus_addr=if_addr; then if_ack.
//  - Store mem_we=1, sel=4'b0011, wdata=0xDEAD_BEEF, addr=0x80 -> bus_we=1, bus_sel=0011,
//    bus_wdata=0xDEAD_BEEF held until bus_ack (delayed 5 cycles); mem_ack 1 cycle after bus_ack.
//  - TIMEOUT_CYC=4 and bus_ack never asserted -> err and if_ack pulse together with if_rdata=0;
//    bus_req low; FSM back in IDLE.
//  - rst pulled low while in MEM_BUSY with bus_req=1 -> all outputs 0 immediately. After release,
//    a pending if_req is served normally and no stale mem_ack appears.
//  - if_req dropped the cycle after grant -> bus completes on bus_ack; if_ack stays 0; the next
//    mem_req is granted after the turnaround cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory bus between the instruction
// fetch requester and the data (load/store) requester. MEM has strict priority.
// Every transaction is bounded by a timeout so the pipeline can never hang.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_ack,
   output logic                if_stallreq,
   input  logic                mem_req,
   input  logic                mem_we,
   input  logic [DATA_W/8-1:0] mem_sel,
   input  logic [ADDR_W-1:0]   mem_addr,
   input  logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W-1:0]   mem_rdata,
   output logic                mem_ack,
   output logic                mem_stallreq,
   output logic                bus_req,
   output logic                bus_we,
   output logic [DATA_W/8-1:0] bus_sel,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic [DATA_W-1:0]   bus_wdata,
   input  logic [DATA_W-1:0]   bus_rdata,
   input  logic                bus_ack,
   output logic                err
);

   localparam int unsigned SEL_W = DATA_W / 8;
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_ABORT = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      IF_BUSY  = 2'd1,
      MEM_BUSY = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                bus_req_q, bus_req_d;
   logic                bus_we_q, bus_we_d;
   logic [SEL_W-1:0]    bus_sel_q, bus_sel_d;
   logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
   logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   // keep_q: owner has held its request continuously since the grant
   logic                keep_q, keep_d;
   logic                if_ack_q, if_ack_d;
   logic                mem_ack_q, mem_ack_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
   logic                err_q, err_d;

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_sel_d   = bus_sel_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      cnt_d       = '0;
      keep_d      = keep_q;
      if_ack_d    = 1'b0;
      mem_ack_d   = 1'b0;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      err_d       = 1'b0;

      case (state_q)
         IDLE: begin
            // A requester whose ack is pulsing now still shows its old request;
            // it is not eligible this cycle (this is the turnaround cycle).
            if (mem_req && !mem_ack_q) begin
               state_d     = MEM_BUSY;
               bus_req_d   = 1'b1;
               bus_we_d    = mem_we;
               bus_sel_d   = mem_sel;
               bus_addr_d  = mem_addr;
               bus_wdata_d = mem_wdata;
               keep_d      = 1'b1;
            end else if (if_req && !if_ack_q) begin
               state_d     = IF_BUSY;
               bus_req_d   = 1'b1;
               bus_we_d    = 1'b0;
               bus_sel_d   = '1;
               bus_addr_d  = if_addr;
               bus_wdata_d = '0;
               keep_d      = 1'b1;
            end
         end

         IF_BUSY: begin
            if (bus_ack) begin
               state_d   = IDLE;
               bus_req_d = 1'b0;
               if (keep_q && if_req) begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = bus_rdata;
               end
            end else if (cnt_q == CNT_ABORT) begin
               state_d   = IDLE;
               bus_req_d = 1'b0;
               err_d     = 1'b1;
               if (keep_q && if_req) begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = '0;
               end
            end else begin
               cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
               keep_d = keep_q & if_req;
            end
         end

         MEM_BUSY: begin
            if (bus_ack) begin
               state_d   = IDLE;
               bus_req_d = 1'b0;
               if (keep_q && mem_req) begin
                  mem_ack_d   = 1'b1;
                  mem_rdata_d = bus_we_q ? '0 : bus_rdata;
               end
            end else if (cnt_q == CNT_ABORT) begin
               state_d   = IDLE;
               bus_req_d = 1'b0;
               err_d     = 1'b1;
               if (keep_q && mem_req) begin
                  mem_ack_d   = 1'b1;
                  mem_rdata_d = '0;
               end
            end else begin
               cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
               keep_d = keep_q & mem_req;
            end
         end

         default: begin
            state_d   = IDLE;
            bus_req_d = 1'b0;
         end
      endcase
   end

   // State and output registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_sel_q   <= '0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         cnt_q       <= '0;
         keep_q      <= 1'b0;
         if_ack_q    <= 1'b0;
         mem_ack_q   <= 1'b0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_sel_q   <= bus_sel_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         cnt_q       <= cnt_d;
         keep_q      <= keep_d;
         if_ack_q    <= if_ack_d;
         mem_ack_q   <= mem_ack_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
         err_q       <= err_d;
      end
   end

   // Stall requests: combinational from request and the registered ack;
   // forced low while reset is asserted so every output reads 0.
   always_comb begin
      if_stallreq  = rst & if_req  & ~if_ack_q;
      mem_stallreq = rst & mem_req & ~mem_ack_q;
   end

   assign if_rdata  = if_rdata_q;
   assign if_ack    = if_ack_q;
   assign mem_rdata = mem_rdata_q;
   assign mem_ack   = mem_ack_q;
   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_sel   = bus_sel_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed vectors, scoreboard queue of
// expected acks, monitor pops and compares on every ack/err pulse.
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst;

   // main instance (TIMEOUT_CYC=16)
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack, if_stallreq;
   logic        mem_req, mem_we;
   logic [3:0]  mem_sel;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ack, mem_stallreq;
   logic        bus_req, bus_we;
   logic [3:0]  bus_sel;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic        bus_ack, err;

   // timeout instance (TIMEOUT_CYC=4), fetch side only exercised
   logic        t_if_req;
   logic [31:0] t_if_addr, t_if_rdata;
   logic        t_if_ack, t_if_stallreq;
   logic        t_mem_req, t_mem_we;
   logic [3:0]  t_mem_sel;
   logic [31:0] t_mem_addr, t_mem_wdata, t_mem_rdata;
   logic        t_mem_ack, t_mem_stallreq;
   logic        t_bus_req, t_bus_we;
   logic [3:0]  t_bus_sel;
   logic [31:0] t_bus_addr, t_bus_wdata, t_bus_rdata;
   logic        t_bus_ack, t_err;

   int unsigned tests;
   int unsigned fails;

   typedef struct {
      int unsigned who;   // 0 main IF, 1 main MEM, 2 timeout-instance IF
      logic [31:0] data;
      logic        e;
   } exp_t;

   exp_t sbq[$];

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
      .if_ack(if_ack), .if_stallreq(if_stallreq),
      .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack), .mem_stallreq(mem_stallreq),
      .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
      .bus_ack(bus_ack), .err(err)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) u_to (
      .clk(clk), .rst(rst),
      .if_req(t_if_req), .if_addr(t_if_addr), .if_rdata(t_if_rdata),
      .if_ack(t_if_ack), .if_stallreq(t_if_stallreq),
      .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_sel(t_mem_sel),
      .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata), .mem_rdata(t_mem_rdata),
      .mem_ack(t_mem_ack), .mem_stallreq(t_mem_stallreq),
      .bus_req(t_bus_req), .bus_we(t_bus_we), .bus_sel(t_bus_sel),
      .bus_addr(t_bus_addr), .bus_wdata(t_bus_wdata), .bus_rdata(t_bus_rdata),
      .bus_ack(t_bus_ack), .err(t_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input int unsigned w, input logic [31:0] d, input logic e);
      exp_t x;
      x.who  = w;
      x.data = d;
      x.e    = e;
      sbq.push_back(x);
   endtask

   task automatic pop_check(input int unsigned w, input logic [31:0] d, input logic e);
      exp_t x;
      if (sbq.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL sb_unexpected: got ack from src %0d data %0h, expected no ack", w, d);
      end else begin
         x = sbq.pop_front();
         chk("sb_src", 64'(w), 64'(x.who));
         chk("sb_data", 64'(d), 64'(x.data));
         chk("sb_err", 64'(e), 64'(x.e));
      end
   endtask

   // Monitor: every ack / err pulse is matched against the scoreboard
   always @(negedge clk) begin
      if (if_ack)    pop_check(0, if_rdata, err);
      if (mem_ack)   pop_check(1, mem_rdata, err);
      if (t_if_ack)  pop_check(2, t_if_rdata, t_err);
      if (err && !if_ack && !mem_ack) pop_check(3, 32'h0, err);
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      tests = 0; fails = 0;
      rst = 1'b0;
      if_req = 0; if_addr = '0;
      mem_req = 0; mem_we = 0; mem_sel = '0; mem_addr = '0; mem_wdata = '0;
      bus_rdata = '0; bus_ack = 0;
      t_if_req = 0; t_if_addr = '0;
      t_mem_req = 0; t_mem_we = 0; t_mem_sel = '0; t_mem_addr = '0; t_mem_wdata = '0;
      t_bus_rdata = '0; t_bus_ack = 0;

      // reset state, stallreq forced low during reset
      nxt(); nxt();
      if_req = 1; mem_req = 1;
      smp();
      chk("rst_bus_req", 64'(bus_req), 0);
      chk("rst_bus_addr", 64'(bus_addr), 0);
      chk("rst_acks", 64'({if_ack, mem_ack, err}), 0);
      chk("rst_stallreq", 64'({if_stallreq, mem_stallreq}), 0);
      if_req = 0; mem_req = 0;
      nxt();
      rst = 1'b1;
      nxt();

      // single fetch
      if_req = 1; if_addr = 32'h100;
      push(0, 32'h2402_0005, 1'b0);
      smp();
      chk("f_c0_stall", 64'(if_stallreq), 1);
      chk("f_c0_bus_req", 64'(bus_req), 0);
      nxt();
      bus_ack = 1; bus_rdata = 32'h2402_0005;
      smp();
      chk("f_c1_bus", 64'({bus_req, bus_we, bus_sel}), 64'({1'b1, 1'b0, 4'hF}));
      chk("f_c1_addr", 64'(bus_addr), 64'h100);
      chk("f_c1_wdata", 64'(bus_wdata), 0);
      chk("f_c1_stall", 64'(if_stallreq), 1);
      nxt();
      bus_ack = 0; bus_rdata = '0;
      smp();
      chk("f_c2_ack", 64'(if_ack), 1);
      chk("f_c2_stall", 64'(if_stallreq), 0);
      chk("f_c2_bus_req", 64'(bus_req), 0);
      if_req = 0;
      // spurious bus_ack while idle is ignored
      nxt();
      bus_ack = 1; bus_rdata = 32'hBAD0_BAD0;
      smp();
      chk("idle_bus_req", 64'(bus_req), 0);
      nxt();
      bus_ack = 0;
      smp();
      chk("idle_no_ack", 64'({if_ack, mem_ack, bus_req}), 0);

      // simultaneous requests: MEM first, one idle bus cycle, then IF
      nxt();
      if_req = 1; if_addr = 32'h300;
      mem_req = 1; mem_we = 0; mem_sel = 4'hF; mem_addr = 32'h40; mem_wdata = '0;
      push(1, 32'h1111_2222, 1'b0);
      push(0, 32'h3333_4444, 1'b0);
      smp();
      chk("p_c0_stall", 64'({if_stallreq, mem_stallreq}), 64'(2'b11));
      nxt();
      bus_ack = 1; bus_rdata = 32'h1111_2222;
      smp();
      chk("p_c1_addr", 64'(bus_addr), 64'h40);
      chk("p_c1_req_we", 64'({bus_req, bus_we}), 64'(2'b10));
      nxt();
      bus_ack = 0; bus_rdata = '0;
      smp();
      chk("p_c2_mem_ack", 64'(mem_ack), 1);
      chk("p_c2_idle", 64'(bus_req), 0);
      chk("p_c2_if_stall", 64'(if_stallreq), 1);
      mem_req = 0;
      nxt();
      bus_ack = 1; bus_rdata = 32'h3333_4444;
      smp();
      chk("p_c3_bus_req", 64'(bus_req), 1);
      chk("p_c3_addr", 64'(bus_addr), 64'h300);
      nxt();
      bus_ack = 0; bus_rdata = '0;
      smp();
      chk("p_c4_if_ack", 64'(if_ack), 1);
      if_req = 0;
      nxt();

      // store with bus_ack delayed five cycles
      mem_req = 1; mem_we = 1; mem_sel = 4'b0011; mem_addr = 32'h80; mem_wdata = 32'hDEAD_BEEF;
      push(1, 32'h0, 1'b0);
      smp();
      for (int i = 0; i < 5; i++) begin
         nxt();
         bus_rdata = 32'h5555_AAAA;
         smp();
         chk("s_hold_ctl", 64'({bus_req, bus_we, bus_sel}), 64'({1'b1, 1'b1, 4'b0011}));
         chk("s_hold_data", 64'({bus_addr, bus_wdata}), 64'({32'h80, 32'hDEAD_BEEF}));
         chk("s_hold_stall", 64'({mem_stallreq, mem_ack}), 64'(2'b10));
      end
      nxt();
      bus_ack = 1;
      smp();
      chk("s_ack_cyc_req", 64'(bus_req), 1);
      nxt();
      bus_ack = 0; bus_rdata = '0;
      smp();
      chk("s_mem_ack", 64'(mem_ack), 1);
      chk("s_stall_low", 64'(mem_stallreq), 0);
      chk("s_bus_req_low", 64'(bus_req), 0);
      mem_req = 0; mem_we = 0; mem_sel = 4'hF;
      nxt();

      // timeout instance: one good fetch, then a fetch that never gets bus_ack
      t_if_req = 1; t_if_addr = 32'h180;
      push(2, 32'h0000_ABCD, 1'b0);
      smp();
      nxt();
      t_bus_ack = 1; t_bus_rdata = 32'h0000_ABCD;
      smp();
      nxt();
      t_bus_ack = 0; t_bus_rdata = '0;
      smp();
      chk("t_good_ack", 64'(t_if_ack), 1);
      t_if_req = 0;
      nxt();
      t_if_req = 1; t_if_addr = 32'h200;
      push(2, 32'h0, 1'b1);
      smp();
      for (int i = 0; i < 4; i++) begin
         nxt();
         smp();
         chk("t_busy", 64'({t_bus_req, t_err, t_if_ack}), 64'(3'b100));
      end
      nxt();
      smp();
      chk("t_abort", 64'({t_err, t_if_ack, t_bus_req}), 64'(3'b110));
      chk("t_abort_rdata", 64'(t_if_rdata), 0);
      chk("t_abort_stall", 64'(t_if_stallreq), 0);
      t_if_req = 0;
      nxt();
      smp();
      chk("t_back_idle", 64'({t_err, t_bus_req, t_if_ack}), 0);

      // reset while MEM_BUSY, then a pending fetch is served cleanly
      nxt();
      mem_req = 1; mem_we = 0; mem_sel = 4'hF; mem_addr = 32'h90;
      smp();
      nxt();
      smp();
      chk("r_busy", 64'(bus_req), 1);
      if_req = 1; if_addr = 32'h400;
      #2;
      rst = 1'b0;
      #1;
      chk("r_bus_req_drop", 64'(bus_req), 0);
      chk("r_bus_fields", 64'({bus_addr, bus_sel, bus_we}), 0);
      chk("r_stalls", 64'({if_stallreq, mem_stallreq}), 0);
      mem_req = 0;
      nxt();
      nxt();
      rst = 1'b1;
      push(0, 32'h7777_8888, 1'b0);
      smp();
      chk("r_rel_idle", 64'(bus_req), 0);
      nxt();
      bus_ack = 1; bus_rdata = 32'h7777_8888;
      smp();
      chk("r_if_grant", 64'({bus_req, bus_addr}), 64'({1'b1, 32'h400}));
      nxt();
      bus_ack = 0; bus_rdata = '0;
      smp();
      chk("r_if_ack", 64'({if_ack, mem_ack}), 64'(2'b10));
      if_req = 0;
      nxt();

      // fetch abandoned after grant: bus completes, no ack, then MEM granted
      if_req = 1; if_addr = 32'h500;
      smp();
      nxt();
      if_req = 0;
      smp();
      chk("d_granted", 64'(bus_req), 1);
      nxt();
      bus_ack = 1; bus_rdata = 32'h1234_5678;
      smp();
      chk("d_not_aborted", 64'({bus_req, bus_addr}), 64'({1'b1, 32'h500}));
      nxt();
      bus_ack = 0; bus_rdata = '0;
      mem_req = 1; mem_we = 0; mem_sel = 4'hF; mem_addr = 32'h600;
      push(1, 32'h0000_9999, 1'b0);
      smp();
      chk("d_no_if_ack", 64'(if_ack), 0);
      chk("d_turnaround", 64'(bus_req), 0);
      nxt();
      bus_ack = 1; bus_rdata = 32'h0000_9999;
      smp();
      chk("d_mem_grant", 64'({bus_req, bus_addr}), 64'({1'b1, 32'h600}));
      nxt();
      bus_ack = 0; bus_rdata = '0;
      smp();
      chk("d_mem_ack", 64'(mem_ack), 1);
      mem_req = 0;
      nxt(); nxt();
      smp();

      chk("sb_empty", 64'(sbq.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
